// File: rtl/psychic5_sound_pkg.sv
// Shared definitions for the Psychic 5 sound post-filter: FSM states,
// saturation bounds and the clamp helper used by the shared datapath.
package psychic5_sound_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HPF,
    ST_LP1,
    ST_LP2,
    ST_OUT
  } snd_state_t;

  localparam int CLAMP_W = 48;
  localparam logic signed [CLAMP_W-1:0] SAT_HI = 48'sd32767;
  localparam logic signed [CLAMP_W-1:0] SAT_LO = -48'sd32768;

  // Bounds scale with the fractional width so callers only size-cast the result.
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(
    input logic signed [CLAMP_W-1:0] v,
    input int unsigned               frac
  );
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    logic signed [CLAMP_W-1:0] r;
    hi = SAT_HI <<< frac;
    lo = SAT_LO <<< frac;
    r  = v;
    if (v > hi) r = hi;
    if (v < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/psychic5_sound_postfilter_sat_shiftacc.sv
// Shared shift-and-add stage: y = clamp(a + ((b - c) >>> s)).
module psychic5_sat_shiftacc
  import psychic5_sound_pkg::*;
#(
  parameter int W    = 26,
  parameter int FRAC = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic        [4:0]   s,
  output logic signed [W-1:0] y
);

  logic signed [W:0]         diff;
  logic signed [W:0]         diff_sh;
  logic signed [W+1:0]       sum;
  logic signed [CLAMP_W-1:0] wide;

  always_comb begin
    diff    = $signed({b[W-1], b}) - $signed({c[W-1], c});
    diff_sh = diff >>> s;
    sum     = $signed({{2{a[W-1]}}, a}) + $signed({diff_sh[W], diff_sh});
    wide    = {{(CLAMP_W-W-2){sum[W+1]}}, sum};
    y       = W'(sat_clamp(wide, FRAC));
  end

endmodule

// File: rtl/psychic5_sound_postfilter.sv
// Sound output network model: DC-blocking high-pass then two one-pole
// low-pass stages, sequenced over one shared saturating shift-accumulator.
module psychic5_sound_postfilter
  import psychic5_sound_pkg::*;
#(
  parameter int HPF_SHIFT = 10,
  parameter int LPF_SHIFT = 2,
  parameter int FRAC      = 8
) (
  input  logic               i_EMU_MCLK,
  input  logic               i_EMU_INITRST_n,
  input  logic               i_SAMPLE_CEN_n,
  input  logic signed [15:0] i_SND_IN,
  input  logic               i_FILTER_EN,
  output logic signed [15:0] o_SND,
  output logic               o_SND_VALID,
  output logic               o_BUSY,
  output logic               o_OVERRUN
);

  localparam int W = 18 + FRAC;

  snd_state_t state, state_nxt;

  logic               strobe;
  logic signed [15:0] in_lat;
  logic               en_lat;
  logic signed [W-1:0] xs, x_prev, h_prev, l1, l2;
  logic signed [W-1:0] acc_a, acc_b, acc_c, acc_y;
  logic        [4:0]   acc_s;

  assign strobe = ~i_SAMPLE_CEN_n;
  assign xs     = {{(W-16-FRAC){in_lat[15]}}, in_lat, {FRAC{1'b0}}};
  assign o_BUSY = (state != ST_IDLE);

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) state <= ST_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (strobe) state_nxt = ST_HPF;
      ST_HPF:  state_nxt = ST_LP1;
      ST_LP1:  state_nxt = ST_LP2;
      ST_LP2:  state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // HPF is folded into a + ((b - c) >>> 0) with the leak pre-applied to a,
  // so h_prev >>> HPF_SHIFT keeps its own rounding instead of (-h_prev) >>> s.
  always_comb begin
    acc_a = l1;
    acc_b = h_prev;
    acc_c = l1;
    acc_s = 5'(LPF_SHIFT);
    case (state)
      ST_HPF: begin
        acc_a = h_prev - (h_prev >>> HPF_SHIFT);
        acc_b = xs;
        acc_c = x_prev;
        acc_s = '0;
      end
      ST_LP2: begin
        acc_a = l2;
        acc_b = l1;
        acc_c = l2;
      end
      default: ;
    endcase
  end

  psychic5_sat_shiftacc #(
    .W    (W),
    .FRAC (FRAC)
  ) u_acc (
    .a (acc_a),
    .b (acc_b),
    .c (acc_c),
    .s (acc_s),
    .y (acc_y)
  );

  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
    if (!i_EMU_INITRST_n) begin
      in_lat      <= '0;
      en_lat      <= 1'b0;
      x_prev      <= '0;
      h_prev      <= '0;
      l1          <= '0;
      l2          <= '0;
      o_SND       <= '0;
      o_SND_VALID <= 1'b0;
      o_OVERRUN   <= 1'b0;
    end else begin
      o_SND_VALID <= 1'b0;
      if (strobe && state != ST_IDLE) o_OVERRUN <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            in_lat <= i_SND_IN;
            en_lat <= i_FILTER_EN;
          end
        end
        ST_HPF: begin
          if (en_lat) begin
            x_prev <= xs;
            h_prev <= acc_y;
          end else begin
            x_prev <= '0;
            h_prev <= '0;
            l1     <= '0;
            l2     <= '0;
          end
        end
        ST_LP1: if (en_lat) l1 <= acc_y;
        ST_LP2: if (en_lat) l2 <= acc_y;
        ST_OUT: begin
          o_SND       <= en_lat ? l2[FRAC+15:FRAC] : in_lat;
          o_SND_VALID <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psychic5_sound_postfilter.sv
// Directed bench with a reference model feeding per-instance scoreboards;
// a second instance uses LPF_SHIFT=0 to reach the saturation bounds.
module tb_psychic5_sound_postfilter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               cen0_n, en0, val0, busy0, ovr0;
  logic signed [15:0] in0, snd0;
  logic               cen1_n, en1, val1, busy1, ovr1;
  logic signed [15:0] in1, snd1;

  psychic5_sound_postfilter u_dut (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST_n (rst_n),
    .i_SAMPLE_CEN_n  (cen0_n),
    .i_SND_IN        (in0),
    .i_FILTER_EN     (en0),
    .o_SND           (snd0),
    .o_SND_VALID     (val0),
    .o_BUSY          (busy0),
    .o_OVERRUN       (ovr0)
  );

  psychic5_sound_postfilter #(
    .HPF_SHIFT (10),
    .LPF_SHIFT (0),
    .FRAC      (8)
  ) u_sat (
    .i_EMU_MCLK      (clk),
    .i_EMU_INITRST_n (rst_n),
    .i_SAMPLE_CEN_n  (cen1_n),
    .i_SND_IN        (in1),
    .i_FILTER_EN     (en1),
    .o_SND           (snd1),
    .o_SND_VALID     (val1),
    .o_BUSY          (busy1),
    .o_OVERRUN       (ovr1)
  );

  typedef struct {
    longint val;
    longint due;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  longint mx[2], mh[2], ml1[2], ml2[2], last_acc[2];
  bit     movr[2];
  int     hs[2] = '{10, 10};
  int     ls[2] = '{2, 0};

  localparam longint HI = 32767 * 256;
  localparam longint LO = -32768 * 256;

  function automatic longint mclamp(longint v);
    if (v > HI) return HI;
    if (v < LO) return LO;
    return v;
  endfunction

  function automatic longint model_step(int i, longint x, bit en);
    longint xsv, h;
    if (!en) begin
      mx[i] = 0; mh[i] = 0; ml1[i] = 0; ml2[i] = 0;
      return x;
    end
    xsv    = x * 256;
    h      = mclamp(xsv - mx[i] + mh[i] - (mh[i] >>> hs[i]));
    mx[i]  = xsv;
    mh[i]  = h;
    ml1[i] = mclamp(ml1[i] + ((h - ml1[i]) >>> ls[i]));
    ml2[i] = mclamp(ml2[i] + ((ml1[i] - ml2[i]) >>> ls[i]));
    return ml2[i] >>> 8;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input int i);
    logic               v;
    logic signed [15:0] s;
    int                 n;
    exp_t               e;
    v = (i == 0) ? val0 : val1;
    s = (i == 0) ? snd0 : snd1;
    n = (i == 0) ? q0.size() : q1.size();
    if (n > 0) e = (i == 0) ? q0[0] : q1[0];
    if (v) begin
      if (n == 0) chk($sformatf("spurious_valid%0d", i), v, 0);
      else begin
        chk($sformatf("snd%0d", i), s, e.val);
        chk($sformatf("latency%0d", i), cyc, e.due);
        if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end else if (n > 0 && cyc >= e.due) begin
      chk($sformatf("missing_valid%0d", i), v, 1);
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_out(0);
    check_out(1);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int i, input longint x, input bit en);
    longint edge_n;
    exp_t   e;
    edge_n = cyc + 1;
    if (i == 0) begin cen0_n = 1'b0; in0 = 16'(x); en0 = en; end
    else        begin cen1_n = 1'b0; in1 = 16'(x); en1 = en; end
    if (edge_n >= last_acc[i] + 5) begin
      last_acc[i] = edge_n;
      e.val = model_step(i, x, en);
      e.due = edge_n + 4;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
    end else begin
      movr[i] = 1'b1;
    end
    tick();
    cen0_n = 1'b1;
    cen1_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; mh[i] = 0; ml1[i] = 0; ml2[i] = 0;
      last_acc[i] = -100;
      movr[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_snd_now", snd0, 0);
    chk("rst_busy_now", busy0, 0);
    cen0_n = 1'b0;
    cen1_n = 1'b0;
    in0 = 16'sd1234;
    in1 = -16'sd777;
    for (int k = 0; k < n; k++) begin
      tick();
      chk("rst_snd0", snd0, 0);
      chk("rst_valid0", val0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_ovr0", ovr0, 0);
      chk("rst_snd1", snd1, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_ovr1", ovr1, 0);
    end
    cen0_n = 1'b1;
    cen1_n = 1'b1;
    rst_n  = 1'b1;
  endtask

  initial begin
    logic signed [15:0] r;
    rst_n = 1'b0;
    cen0_n = 1'b1; in0 = '0; en0 = 1'b1;
    cen1_n = 1'b1; in1 = '0; en1 = 1'b1;
    model_reset();
    #2;
    do_reset(4);
    tick();

    // first step sample and busy window
    send(0, 1000, 1'b1);
    chk("busy_after_strobe", busy0, 1);
    idle(3);
    chk("busy_in_out", busy0, 1);
    tick();
    chk("step_first", snd0, 62);
    chk("busy_back_idle", busy0, 0);

    for (int k = 0; k < 30; k++) begin send(0, 1000, 1'b1); idle(4); end
    for (int k = 0; k < 10; k++) begin send(0, 0, 1'b1); idle(4); end
    for (int k = 0; k < 8; k++) begin
      r = 16'($urandom());
      send(0, r, 1'b1);
      idle(4);
    end
    chk("no_overrun_5apart", ovr0, 0);

    send(0, -12345, 1'b0);
    idle(4);
    chk("bypass", snd0, -12345);
    send(0, 1000, 1'b1);
    idle(4);
    chk("reenable_clean", snd0, 62);

    // filter enable changed mid-sequence must not affect this sample
    send(0, 1000, 1'b1);
    en0 = 1'b0;
    idle(4);
    en0 = 1'b1;

    send(0, 500, 1'b1);
    idle(3);
    send(0, 700, 1'b1);
    chk("overrun_at_out", ovr0, movr[0]);
    idle(4);

    do_reset(2);
    tick();
    send(0, 1000, 1'b1);
    idle(1);
    send(0, 200, 1'b1);
    idle(4);
    chk("overrun_2apart", ovr0, 1);
    chk("overrun_first_kept", snd0, 62);
    idle(6);
    chk("overrun_sticky", ovr0, movr[0]);

    send(0, 1000, 1'b1);
    tick();
    do_reset(3);
    tick();
    send(0, 1000, 1'b1);
    idle(4);
    chk("after_midreset", snd0, 62);

    send(1, -32768, 1'b1);
    idle(4);
    chk("sat_neg", snd1, -32768);
    send(1, 32767, 1'b1);
    idle(4);
    chk("sat_pos", snd1, 32767);
    send(1, -32768, 1'b1);
    idle(4);
    chk("sat_neg_again", snd1, -32768);

    idle(3);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psychic5_sound_postfilter.md
# psychic5_sound_postfilter

Digital stand-in for the analog output network after the sound board mixer. It takes the mixed signed 16-bit OPN/PSG sum and applies a DC-blocking high-pass (the 10u coupling caps) followed by two one-pole low-pass stages (the 1k/6.8n/4.7n RC network). Each accepted sample passes through a small multi-cycle state machine that shares one shift-and-add datapath. The output is saturated to 16 bits and feeds the top-level audio output.

## Interface
- HPF_SHIFT, 10: high-pass leak shift; pole = 1 - 2^-HPF_SHIFT.
- LPF_SHIFT, 2: low-pass gain shift for both LP stages; alpha = 2^-LPF_SHIFT.
- FRAC, 8: fractional bits kept in the internal state.

Ports:
- i_EMU_MCLK  in  1  system clock; every register is on its rising edge.
- i_EMU_INITRST_n  in  1  reset, asynchronous, active-low.
- i_SAMPLE_CEN_n  in  1  active-low one-clock sample strobe.
- i_SND_IN  in  16  signed mixed sound sample, sampled on the strobe.
- i_FILTER_EN  in  1  1 = filter active, 0 = bypass.
- o_SND  out  16  signed filtered sample.
- o_SND_VALID  out  1  one-clock pulse when o_SND updates.
- o_BUSY  out  1  high while the FSM is not in IDLE.
- o_OVERRUN  out  1  sticky: a strobe arrived while busy.

## Operation
- Internal width W = 18+FRAC bits, signed. The scaled input is xs = i_SND_IN <<< FRAC.
- Clamp: every stage result saturates to [-32768<<<FRAC, 32767<<<FRAC].
- FSM states: IDLE, HPF, LP1, LP2, OUT.
- IDLE: on a strobe, latch xs and go to HPF. With no strobe, stay in IDLE.
- HPF: h = clamp(xs - x_prev + h_prev - (h_prev >>> HPF_SHIFT)). Then x_prev <= xs, h_prev <= h. Go to LP1.
- LP1: l1 = clamp(l1 + ((h - l1) >>> LPF_SHIFT)). Go to LP2.
- LP2: l2 = clamp(l2 + ((l1 - l2) >>> LPF_SHIFT)). Go to OUT.
- OUT: o_SND <= l2 >>> FRAC (arithmetic shift, truncation toward -inf). Pulse o_SND_VALID. Go to IDLE.
- Bypass (i_FILTER_EN=0): the FSM sequence and latency are unchanged. OUT loads the latched i_SND_IN instead. x_prev, h_prev, l1 and l2 are held at 0, so re-enabling starts from a clean state.
- i_FILTER_EN is sampled once, in IDLE, on the strobe. Changing it mid-sequence has no effect until the next sample.
- Strobe outside IDLE: the sample is dropped and o_OVERRUN is set to 1. The flag stays set until reset.

## Timing
- Reset values: o_SND=0, o_SND_VALID=0, o_BUSY=0, o_OVERRUN=0. All filter state is 0 and the FSM is in IDLE.
- Strobe at clock edge N: o_BUSY is high from N+1 to N+4. o_SND and o_SND_VALID update at N+4 (latency 4 clocks).
- Minimum strobe spacing is 5 clocks. A strobe exactly at N+4, when the FSM is in OUT, counts as an overrun. A strobe at N+5 is accepted.
- Reset asserted mid-sequence clears everything immediately. No o_SND_VALID pulse is produced for the aborted sample.
- o_SND holds its value between pulses.

## Structure
- Shared sound package holds the FSM state enum (IDLE/HPF/LP1/LP2/OUT), the saturation bounds, and a clamp function parameterised on W and FRAC.
- One sub-module is natural: psychic5_sat_shiftacc. It computes clamp(a + ((b - c) >>> s)) and is reused by the HPF, LP1 and LP2 states through a mux.

## Test plan
- Reset: hold i_EMU_INITRST_n low with strobes active. Required: all outputs 0 and no o_SND_VALID.
- Step, defaults: first strobe with i_SND_IN=1000. Required: o_SND=62 exactly 4 clocks later (h=1000, l1=250, l2=62.5 truncated to 62). Further strobes of 1000 rise toward roughly 1000, then decay toward 0 (the DC block).
- Bypass: i_FILTER_EN=0 with input -12345. Required: o_SND=-12345 at +4 clocks. Filter state reads 0.
- Saturation: HPF_SHIFT=10, LPF_SHIFT=0. Send -32768, then 32767. Required: h clamps at the positive bound, second output is 32767, no wrap to negative.
- Overrun: strobes 2 clocks apart. Required: second sample dropped, exactly one o_SND_VALID pulse, o_OVERRUN=1 until reset. Strobes 5 apart produce no overrun.
- Mid-op reset: assert reset in LP1. Required: immediate zeroing. A fresh 1000 step afterwards reproduces 62.
